// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

  // One queued writeback: destination register and the value to write.
  typedef struct packed {
    reg_idx_t  idx;
    reg_data_t data;
  } wb_entry_t;

  // Writes to r0 are swallowed when the hardwired-zero register is enabled.
  function automatic logic is_dropped(input reg_idx_t idx, input bit drop_r0);
    return drop_r0 && (idx == '0);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the two writeback request channels, the register-file write port,
// the pending mask and the forwarding lookup. Latency: n/a (wires only).
// Backpressure: src*_ready per channel; the register-file side never stalls.
//   src0_*/src1_* : valid/ready/idx/data request channels (master drives valid/idx/data)
//   regWrite/writeReg/writeData : register-file write port (slave drives)
//   pending : per-register queued-write mask; fwd_idx/fwd_hit/fwd_data : lookup port
interface reg_wb_arbiter_if;
  import reg_wb_arbiter_pkg::*;

  logic      src0_valid;
  logic      src0_ready;
  reg_idx_t  src0_idx;
  reg_data_t src0_data;

  logic      src1_valid;
  logic      src1_ready;
  reg_idx_t  src1_idx;
  reg_data_t src1_data;

  logic      regWrite;
  reg_idx_t  writeReg;
  reg_data_t writeData;

  logic [NUM_REGS-1:0] pending;

  reg_idx_t  fwd_idx;
  logic      fwd_hit;
  reg_data_t fwd_data;

  modport master (
    output src0_valid, src0_idx, src0_data,
    output src1_valid, src1_idx, src1_data,
    output fwd_idx,
    input  src0_ready, src1_ready,
    input  regWrite, writeReg, writeData,
    input  pending, fwd_hit, fwd_data
  );

  modport slave (
    input  src0_valid, src0_idx, src0_data,
    input  src1_valid, src1_idx, src1_data,
    input  fwd_idx,
    output src0_ready, src1_ready,
    output regWrite, writeReg, writeData,
    output pending, fwd_hit, fwd_data
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_queue.sv
// In-order circular writeback buffer with two push ports and one pop port.
// Latency: a push is visible at the head/entries one cycle later.
// Backpressure: none internally; the caller guarantees pushes never exceed free space.
//   clk/reset : clock, synchronous active-high reset (empties the queue)
//   push0_*/push1_* : push ports, push0 is older when both fire
//   pop : remove head; head_dat/count_o/head_ptr_o/entries_o/valid_o : state view
module reg_wb_arbiter_wb_queue
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push0_vld,
  input  wb_entry_t             push0_dat,
  input  logic                  push1_vld,
  input  wb_entry_t             push1_dat,
  input  logic                  pop,
  output wb_entry_t             head_dat,
  output logic [CW-1:0]         count_o,
  output logic [PW-1:0]         head_ptr_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o
);

  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         tail1;

  // push1 lands right behind push0, or at the tail itself when push0 is idle.
  assign tail1 = tail_q + PW'(push0_vld);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PW'(push0_vld) + PW'(push1_vld);
      if (pop) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push0_vld) + CW'(push1_vld) - CW'(pop);
    end
  end

  // Storage needs no reset: liveness is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push0_vld) mem_q[tail_q] <= push0_dat;
    if (push1_vld) mem_q[tail1]  <= push1_dat;
  end

  // A slot is live when its distance from the head is below the fill count.
  always_comb begin
    logic [PW-1:0] age;
    age     = '0;
    valid_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      age        = PW'(s) - head_q;
      valid_o[s] = (CW'(age) < count_q);
    end
  end

  assign head_dat   = mem_q[head_q];
  assign count_o    = count_q;
  assign head_ptr_o = head_q;
  assign entries_o  = mem_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges integer-pipe and FP/DSP-pipe writebacks into one in-order register-file write port.
// Latency: accept at edge N -> register-file write enable during N..N+1 when the queue is empty.
// Backpressure: src*_ready from free slots; src0 preferred until src1 has stalled STARVE_LIMIT cycles.
//   clk/reset : clock, synchronous active-high reset (discards all queued writes)
//   bus       : slave side of reg_wb_arbiter_if (requests, write port, pending mask, forwarding)
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter bit DROP_R0      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  reg_wb_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = CW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // ---------------- queue ----------------
  logic                  push0_vld, push1_vld, pop;
  wb_entry_t             push0_dat, push1_dat, head_dat;
  logic [CW-1:0]         count;
  logic [PW-1:0]         head_ptr;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      ent_vld;

  reg_wb_arbiter_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push0_vld  (push0_vld),
    .push0_dat  (push0_dat),
    .push1_vld  (push1_vld),
    .push1_dat  (push1_dat),
    .pop        (pop),
    .head_dat   (head_dat),
    .count_o    (count),
    .head_ptr_o (head_ptr),
    .entries_o  (entries),
    .valid_o    (ent_vld)
  );

  // ---------------- arbitration ----------------
  logic [SW-1:0] starve_q;
  logic [FW-1:0] free;
  logic          src1_wins;
  logic          w_vld, l_vld, w_rdy, l_rdy, w_cons;
  wb_entry_t     w_ent, l_ent;
  logic          src0_rdy, src1_rdy;

  assign pop = (count != '0);

  // The head pops this cycle whenever the queue is non-empty, so its slot counts as free.
  assign free = FW'(DEPTH) - FW'(count) + FW'(pop);

  assign src1_wins = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    w_vld = bus.src0_valid;
    w_ent = '{idx: bus.src0_idx, data: bus.src0_data};
    l_vld = bus.src1_valid;
    l_ent = '{idx: bus.src1_idx, data: bus.src1_data};
    if (src1_wins) begin
      w_vld = bus.src1_valid;
      w_ent = '{idx: bus.src1_idx, data: bus.src1_data};
      l_vld = bus.src0_valid;
      l_ent = '{idx: bus.src0_idx, data: bus.src0_data};
    end
  end

  // A dropped r0 write from the winner takes no slot, so the loser only needs one.
  assign w_cons = w_vld && !is_dropped(w_ent.idx, DROP_R0);
  assign w_rdy  = (free >= FW'(1));
  assign l_rdy  = (free >= (w_cons ? FW'(2) : FW'(1)));

  assign src0_rdy = src1_wins ? l_rdy : w_rdy;
  assign src1_rdy = src1_wins ? w_rdy : l_rdy;

  assign bus.src0_ready = src0_rdy;
  assign bus.src1_ready = src1_rdy;

  // Winner goes to push0 so it is older than the loser when both are accepted.
  assign push0_vld = w_vld && w_rdy && !is_dropped(w_ent.idx, DROP_R0);
  assign push0_dat = w_ent;
  assign push1_vld = l_vld && l_rdy && !is_dropped(l_ent.idx, DROP_R0);
  assign push1_dat = l_ent;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (bus.src1_valid && src1_rdy) begin
      starve_q <= '0;
    end else if (bus.src1_valid && !src1_rdy && !src1_wins) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // ---------------- pending counters ----------------
  logic [CW-1:0]       pcnt_q [NUM_REGS];
  logic [CW-1:0]       pcnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pcnt_d[r] = pcnt_q[r]
                + CW'(push0_vld && (push0_dat.idx == REG_IDX_W'(r)))
                + CW'(push1_vld && (push1_dat.idx == REG_IDX_W'(r)))
                - CW'(pop && (head_dat.idx == REG_IDX_W'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pcnt_q[r]    <= pcnt_d[r];
        pending_q[r] <= (pcnt_d[r] != '0);
      end
    end
  end

  assign bus.pending = pending_q;

  // ---------------- write port ----------------
  assign bus.regWrite  = pop;
  assign bus.writeReg  = pop ? head_dat.idx  : '0;
  assign bus.writeData = pop ? head_dat.data : '0;

  // ---------------- forwarding ----------------
  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot         = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_ptr + PW'(k);
      if (ent_vld[slot] && (entries[slot].idx == bus.fwd_idx)
          && !is_dropped(bus.fwd_idx, DROP_R0)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = entries[slot].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter (DEPTH=4, STARVE_LIMIT=3, DROP_R0=1).
// Latency: n/a. Backpressure: drives valids independent of ready.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_wb_arbiter_if bus();

  reg_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3), .DROP_R0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.src0_valid = 1'b0;
    bus.src0_idx   = '0;
    bus.src0_data  = '0;
    bus.src1_valid = 1'b0;
    bus.src1_idx   = '0;
    bus.src1_data  = '0;
  endtask

  task automatic drive0(input logic [4:0] idx, input logic [31:0] data);
    bus.src0_valid = 1'b1;
    bus.src0_idx   = idx;
    bus.src0_data  = data;
  endtask

  task automatic drive1(input logic [4:0] idx, input logic [31:0] data);
    bus.src1_valid = 1'b1;
    bus.src1_idx   = idx;
    bus.src1_data  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] exp_rdy0;
    logic [11:0] exp_rdy1;
    wb_entry_t   sb[$];
    wb_entry_t   e;
    int          last_acc1;
    logic        a0, a1;

    idle();
    bus.fwd_idx = 5'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;

    // ---- reset state ----
    check("rst_regWrite",  {31'd0, bus.regWrite}, 32'd0);
    check("rst_writeReg",  {27'd0, bus.writeReg}, 32'd0);
    check("rst_writeData", bus.writeData, 32'd0);
    check("rst_pending",   bus.pending, 32'd0);
    check("rst_fwd_hit",   {31'd0, bus.fwd_hit}, 32'd0);

    // ---- 1: single src0 write ----
    drive0(5'd5, 32'hDEADBEEF);
    #1;
    check("t1_src0_ready", {31'd0, bus.src0_ready}, 32'd1);
    step();
    idle();
    check("t1_regWrite",  {31'd0, bus.regWrite}, 32'd1);
    check("t1_writeReg",  {27'd0, bus.writeReg}, 32'd5);
    check("t1_writeData", bus.writeData, 32'hDEADBEEF);
    check("t1_pending",   bus.pending, 32'h0000_0020);
    step();
    check("t1_regWrite_off", {31'd0, bus.regWrite}, 32'd0);
    check("t1_pending_off",  bus.pending, 32'd0);

    // ---- 2: both sources same cycle, src0 older ----
    drive0(5'd3, 32'h11);
    drive1(5'd4, 32'h22);
    #1;
    check("t2_src0_ready", {31'd0, bus.src0_ready}, 32'd1);
    check("t2_src1_ready", {31'd0, bus.src1_ready}, 32'd1);
    step();
    idle();
    check("t2_w1_reg",  {27'd0, bus.writeReg}, 32'd3);
    check("t2_w1_data", bus.writeData, 32'h11);
    check("t2_pend1",   bus.pending, 32'h0000_0018);
    step();
    check("t2_w2_reg",  {27'd0, bus.writeReg}, 32'd4);
    check("t2_w2_data", bus.writeData, 32'h22);
    check("t2_pend2",   bus.pending, 32'h0000_0010);
    step();
    check("t2_idle", {31'd0, bus.regWrite}, 32'd0);

    // ---- 3: both valid every cycle, starvation relief and write order ----
    exp_rdy0  = 12'hBBF;
    exp_rdy1  = 12'h447;
    last_acc1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.regWrite) begin
        check("t3_sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("t3_wreg", {27'd0, bus.writeReg}, {27'd0, e.idx});
          check("t3_wdat", bus.writeData, e.data);
        end
      end
      if (i < 12) begin
        drive0(5'd1, 32'h1000 + i);
        drive1(5'd2, 32'h2000 + i);
        #1;
        a0 = bus.src0_ready;
        a1 = bus.src1_ready;
        check($sformatf("t3_rdy0_c%0d", i), {31'd0, a0}, {31'd0, exp_rdy0[i]});
        check($sformatf("t3_rdy1_c%0d", i), {31'd0, a1}, {31'd0, exp_rdy1[i]});
        if (a0) sb.push_back('{idx: 5'd1, data: 32'h1000 + i});
        if (a1) begin
          sb.push_back('{idx: 5'd2, data: 32'h2000 + i});
          if (last_acc1 >= 0) check("t3_starve_gap", {31'd0, (i - last_acc1) <= 4}, 32'd1);
          last_acc1 = i;
        end
      end else begin
        idle();
      end
      step();
    end
    check("t3_drained", sb.size(), 32'd0);
    check("t3_idle", {31'd0, bus.regWrite}, 32'd0);

    // ---- 4: dropped r0 write ----
    bus.fwd_idx = 5'd0;
    drive0(5'd0, 32'hFFFF);
    #1;
    check("t4_src0_ready", {31'd0, bus.src0_ready}, 32'd1);
    step();
    idle();
    check("t4_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("t4_pending",  bus.pending, 32'd0);
    check("t4_fwd_hit",  {31'd0, bus.fwd_hit}, 32'd0);
    step();
    check("t4_regWrite2", {31'd0, bus.regWrite}, 32'd0);

    // ---- 5: forwarding ----
    bus.fwd_idx = 5'd7;
    drive0(5'd7, 32'd1);
    drive1(5'd9, 32'd5);
    step();
    idle();
    check("t5_fwd_hit_a",  {31'd0, bus.fwd_hit}, 32'd1);
    check("t5_fwd_data_a", bus.fwd_data, 32'd1);
    check("t5_pend_a",     bus.pending, 32'h0000_0280);
    drive0(5'd7, 32'd2);
    step();
    idle();
    check("t5_w_reg_b",    {27'd0, bus.writeReg}, 32'd9);
    check("t5_fwd_hit_b",  {31'd0, bus.fwd_hit}, 32'd1);
    check("t5_fwd_data_b", bus.fwd_data, 32'd2);
    check("t5_pend_b",     bus.pending, 32'h0000_0280);
    step();
    check("t5_w_data_c",   bus.writeData, 32'd2);
    check("t5_pend_c",     bus.pending, 32'h0000_0080);
    step();
    check("t5_pend_d",     bus.pending, 32'd0);
    check("t5_fwd_hit_d",  {31'd0, bus.fwd_hit}, 32'd0);
    check("t5_fwd_data_d", bus.fwd_data, 32'd0);

    // youngest of several r7 entries, counter handling two pushes + one pop
    drive0(5'd7, 32'hA);
    drive1(5'd7, 32'hB);
    step();
    check("t5_fwd_young_x", bus.fwd_data, 32'hB);
    check("t5_wdat_x",      bus.writeData, 32'hA);
    drive0(5'd7, 32'hC);
    drive1(5'd7, 32'hD);
    #1;
    check("t5_rdy0_y", {31'd0, bus.src0_ready}, 32'd1);
    check("t5_rdy1_y", {31'd0, bus.src1_ready}, 32'd1);
    step();
    idle();
    check("t5_fwd_young_y", bus.fwd_data, 32'hD);
    check("t5_wdat_y",      bus.writeData, 32'hB);
    check("t5_pend_y",      bus.pending, 32'h0000_0080);
    step();
    check("t5_wdat_z1", bus.writeData, 32'hC);
    check("t5_pend_z1", bus.pending, 32'h0000_0080);
    step();
    check("t5_wdat_z2", bus.writeData, 32'hD);
    check("t5_pend_z2", bus.pending, 32'h0000_0080);
    check("t5_fwd_z2",  bus.fwd_data, 32'hD);
    step();
    check("t5_pend_z3", bus.pending, 32'd0);
    check("t5_hit_z3",  {31'd0, bus.fwd_hit}, 32'd0);
    bus.fwd_idx = 5'd9;
    #1;
    check("t5_hit_r9_none", {31'd0, bus.fwd_hit}, 32'd0);

    // ---- 6: reset with entries queued ----
    drive0(5'd1, 32'd1);
    drive1(5'd2, 32'd2);
    step();
    drive0(5'd3, 32'd3);
    drive1(5'd4, 32'd4);
    step();
    idle();
    check("t6_pend_full", bus.pending, 32'h0000_001C);
    bus.fwd_idx = 5'd3;
    #1;
    check("t6_hit_before", {31'd0, bus.fwd_hit}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t6_regWrite",   {31'd0, bus.regWrite}, 32'd0);
    check("t6_writeReg",   {27'd0, bus.writeReg}, 32'd0);
    check("t6_pending",    bus.pending, 32'd0);
    check("t6_fwd_hit",    {31'd0, bus.fwd_hit}, 32'd0);
    check("t6_src0_ready", {31'd0, bus.src0_ready}, 32'd1);
    step();
    check("t6_regWrite2",  {31'd0, bus.regWrite}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
